guess_entry: RTL and testbench

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/game_pkg.sv | 19 +
 rtl/digit_counter.sv | 102 ++++++++++
 rtl/guess_entry.sv | 142 ++++++++++++++
 tb/tb_guess_entry.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared digit width, default radix and guess-entry FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int DIGIT_W       = 4;
    localparam int DEFAULT_RADIX = 10;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } entry_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : digit_counter
// Description : One modulo-RADIX digit with edge-detected inc/dec buttons.
//               Decrement exists only when GUESS_ENTRY_DEC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_counter
    import game_pkg::*;
#(
    parameter int RADIX = DEFAULT_RADIX
) (
    input  logic               clk,
    input  logic               restart,
    input  logic               inc_btn,
    input  logic               dec_btn,
    input  logic               enable,
    input  logic               edit_en,
    input  logic               hold,
    output logic [DIGIT_W-1:0] value
);

    localparam logic [DIGIT_W-1:0] c_MAX = DIGIT_W'(RADIX - 1);
    localparam logic [DIGIT_W-1:0] c_ONE = DIGIT_W'(1);

    logic               r_inc_prev;
    logic               r_inc_arm;
    logic               r_inc_pls;
    logic               w_dec_pls;
    logic [DIGIT_W-1:0] r_value;
    logic [DIGIT_W-1:0] w_next;

    // The arm bit stays clear until the button is seen low, so a button held
    // through restart cannot produce a press when restart drops.
    always_ff @(posedge clk) begin
        if (restart) begin
            r_inc_prev <= 1'b0;
            r_inc_arm  <= ~inc_btn;
            r_inc_pls  <= 1'b0;
        end else begin
            r_inc_prev <= inc_btn;
            r_inc_arm  <= r_inc_arm | ~inc_btn;
            r_inc_pls  <= inc_btn & ~r_inc_prev & r_inc_arm;
        end
    end

`ifdef GUESS_ENTRY_DEC_EN
    logic r_dec_prev;
    logic r_dec_arm;
    logic r_dec_pls;

    always_ff @(posedge clk) begin
        if (restart) begin
            r_dec_prev <= 1'b0;
            r_dec_arm  <= ~dec_btn;
            r_dec_pls  <= 1'b0;
        end else begin
            r_dec_prev <= dec_btn;
            r_dec_arm  <= r_dec_arm | ~dec_btn;
            r_dec_pls  <= dec_btn & ~r_dec_prev & r_dec_arm;
        end
    end

    assign w_dec_pls = r_dec_pls;

    always_comb begin
        w_next = r_value;
        if (r_inc_pls && !w_dec_pls) begin
            w_next = (r_value == c_MAX) ? '0 : r_value + c_ONE;
        end else if (w_dec_pls && !r_inc_pls) begin
            w_next = (r_value == '0) ? c_MAX : r_value - c_ONE;
        end
    end
`else
    logic w_unused_dec;
    assign w_unused_dec = dec_btn;
    assign w_dec_pls    = 1'b0;

    always_comb begin
        w_next = r_value;
        if (r_inc_pls) begin
            w_next = (r_value == c_MAX) ? '0 : r_value + c_ONE;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (restart) begin
            r_value <= '0;
        end else if (!hold) begin
            if (!enable) begin
                r_value <= '0;
            end else if (edit_en) begin
                r_value <= w_next;
            end
        end
    end

    assign value = r_value;

endmodule : digit_counter
`default_nettype wire

// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : guess_entry
// Description : Multi-digit guess editor with confirm/ack handshake and lock.
//               Optional decrement buttons via GUESS_ENTRY_DEC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_entry
    import game_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int RADIX      = DEFAULT_RADIX,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            restart,
    input  logic [$clog2(NUM_DIGITS+1)-1:0] max_digits,
    input  logic [NUM_DIGITS-1:0]           inc_btn,
    input  logic [NUM_DIGITS-1:0]           dec_btn,
    input  logic                            confirm,
    input  logic                            lock,
    input  logic                            guess_ack,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   display_digits,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   guess_digits,
    output logic                            guess_valid,
    output logic [CNT_W-1:0]                guess_count,
    output logic [1:0]                      state
);

    localparam int MD_W = $clog2(NUM_DIGITS + 1);

    entry_state_t                    r_state;
    entry_state_t                    w_cur_state;
    entry_state_t                    w_next_state;
    logic                            w_capture;
    logic                            w_count_inc;
    logic                            w_frozen;
    logic                            w_edit_en;
    logic [NUM_DIGITS-1:0]           w_en;
    logic [NUM_DIGITS*DIGIT_W-1:0]   w_display;
    logic [NUM_DIGITS*DIGIT_W-1:0]   r_guess;
    logic                            r_valid;
    logic [CNT_W-1:0]                r_count;
    logic                            r_cfm_prev;
    logic                            r_cfm_arm;
    logic                            r_cfm_pls;

    // The unused encoding behaves exactly like EDIT.
    assign w_cur_state = (r_state == entry_state_t'(2'd3)) ? EDIT : r_state;
    assign w_frozen    = lock | (w_cur_state == LOCKED);
    assign w_edit_en   = !lock && (w_cur_state == EDIT);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign w_en[i] = (max_digits > MD_W'(i));

        digit_counter #(
            .RADIX   (RADIX)
        ) u_digit (
            .clk     (clk),
            .restart (restart),
            .inc_btn (inc_btn[i]),
            .dec_btn (dec_btn[i]),
            .enable  (w_en[i]),
            .edit_en (w_edit_en),
            .hold    (w_frozen),
            .value   (w_display[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            r_cfm_prev <= 1'b0;
            r_cfm_arm  <= ~confirm;
            r_cfm_pls  <= 1'b0;
        end else begin
            r_cfm_prev <= confirm;
            r_cfm_arm  <= r_cfm_arm | ~confirm;
            r_cfm_pls  <= confirm & ~r_cfm_prev & r_cfm_arm;
        end
    end

    always_comb begin
        w_next_state = w_cur_state;
        w_capture    = 1'b0;
        w_count_inc  = 1'b0;
        if (lock) begin
            w_next_state = LOCKED;
        end else begin
            case (w_cur_state)
                EDIT: begin
                    if (r_cfm_pls) begin
                        w_next_state = PENDING;
                        w_capture    = 1'b1;
                    end
                end
                PENDING: begin
                    if (guess_ack) begin
                        w_next_state = EDIT;
                        w_count_inc  = 1'b1;
                    end
                end
                LOCKED: begin
                    w_next_state = EDIT;
                end
                default: begin
                    w_next_state = EDIT;
                end
            endcase
        end
    end

    // Capture uses the pre-edit display; digit edits in the same cycle still land.
    always_ff @(posedge clk) begin
        if (restart) begin
            r_state <= EDIT;
            r_guess <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (lock) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_guess <= w_display;
                r_valid <= 1'b1;
            end else if (w_count_inc) begin
                r_valid <= 1'b0;
                if (r_count != '1) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign display_digits = w_display;
    assign guess_digits   = r_guess;
    assign guess_valid    = r_valid;
    assign guess_count    = r_count;
    assign state          = w_cur_state;

endmodule : guess_entry
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_entry
// Description : Directed scoreboard bench for guess_entry (3 digits, CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

    localparam int NUM_DIGITS = 3;
    localparam int RADIX      = 10;
    localparam int CNT_W      = 2;

    logic        clk = 1'b0;
    logic        restart;
    logic [1:0]  max_digits;
    logic [2:0]  inc_btn;
    logic [2:0]  dec_btn;
    logic        confirm;
    logic        lock;
    logic        guess_ack;
    logic [11:0] display_digits;
    logic [11:0] guess_digits;
    logic        guess_valid;
    logic [1:0]  guess_count;
    logic [1:0]  state;

    always #5 clk = ~clk;

    guess_entry #(
        .NUM_DIGITS     (NUM_DIGITS),
        .RADIX          (RADIX),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .restart        (restart),
        .max_digits     (max_digits),
        .inc_btn        (inc_btn),
        .dec_btn        (dec_btn),
        .confirm        (confirm),
        .lock           (lock),
        .guess_ack      (guess_ack),
        .display_digits (display_digits),
        .guess_digits   (guess_digits),
        .guess_valid    (guess_valid),
        .guess_count    (guess_count),
        .state          (state)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [11:0] exp_disp;
    logic [11:0] exp_guess;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Reference decimal digit arithmetic.
    function automatic logic [11:0] bump(input logic [11:0] d, input int i, input int delta);
        int v;
        v = int'(d[i*4 +: 4]);
        v = (v + delta + RADIX) % RADIX;
        d[i*4 +: 4] = 4'(v);
        return d;
    endfunction

    task automatic press_inc(input int i);
        inc_btn[i] = 1'b1;
        tick();
        inc_btn[i] = 1'b0;
        tick();
    endtask

    task automatic press_dec(input int i);
        dec_btn[i] = 1'b1;
        tick();
        dec_btn[i] = 1'b0;
        tick();
    endtask

    task automatic press_confirm();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        restart    = 1'b1;
        max_digits = 2'd3;
        inc_btn    = '0;
        dec_btn    = '0;
        confirm    = 1'b0;
        lock       = 1'b0;
        guess_ack  = 1'b0;
        tick(2);
        restart = 1'b0;
        tick();

        push("rst_display", 32'h0);
        push("rst_guess", 32'h0);
        push("rst_valid", 32'h0);
        push("rst_count", 32'h0);
        push("rst_state", 32'h0);
        chk(display_digits);
        chk(guess_digits);
        chk(guess_valid);
        chk(guess_count);
        chk(state);

        // Twelve increments on a decimal digit wrap through 9 -> 0.
        exp_disp = '0;
        for (int k = 0; k < 12; k++) begin
            exp_disp = bump(exp_disp, 0, 1);
        end
        push("wrap_d0", 32'(exp_disp));
        for (int k = 0; k < 12; k++) press_inc(0);
        chk(display_digits);

        max_digits = 2'd1;
        push("masked_inc", 32'(exp_disp));
        press_inc(1);
        chk(display_digits);

        max_digits = 2'd2;
        for (int k = 0; k < 5; k++) exp_disp = bump(exp_disp, 1, 1);
        push("d1_five", 32'(exp_disp));
        for (int k = 0; k < 5; k++) press_inc(1);
        chk(display_digits);

        max_digits = 2'd1;
        exp_disp[7:4] = 4'h0;
        push("force_zero", 32'(exp_disp));
        tick();
        chk(display_digits);

        // Build 4,7,1 then confirm together with an inc on digit 0.
        max_digits = 2'd3;
        for (int k = 0; k < 2; k++) exp_disp = bump(exp_disp, 0, 1);
        for (int k = 0; k < 7; k++) exp_disp = bump(exp_disp, 1, 1);
        exp_disp = bump(exp_disp, 2, 1);
        push("digits_471", 32'(exp_disp));
        for (int k = 0; k < 2; k++) press_inc(0);
        for (int k = 0; k < 7; k++) press_inc(1);
        press_inc(2);
        chk(display_digits);

        exp_guess = exp_disp;
        exp_disp  = bump(exp_disp, 0, 1);
        push("cfm_guess", 32'(exp_guess));
        push("cfm_display", 32'(exp_disp));
        push("cfm_valid", 32'h1);
        push("cfm_state", 32'h1);
        confirm    = 1'b1;
        inc_btn[0] = 1'b1;
        tick();
        confirm    = 1'b0;
        inc_btn[0] = 1'b0;
        tick();
        chk(guess_digits);
        chk(display_digits);
        chk(guess_valid);
        chk(state);

        push("pend_display", 32'(exp_disp));
        push("pend_guess", 32'(exp_guess));
        push("pend_state", 32'h1);
        press_inc(1);
        press_confirm();
        chk(display_digits);
        chk(guess_digits);
        chk(state);

        push("ack_valid", 32'h0);
        push("ack_count", 32'h1);
        push("ack_state", 32'h0);
        push("ack_display", 32'(exp_disp));
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        chk(guess_valid);
        chk(guess_count);
        chk(state);
        chk(display_digits);

        push("ack_in_edit", 32'h1);
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        tick();
        chk(guess_count);

`ifdef GUESS_ENTRY_DEC_EN
        exp_disp = bump(exp_disp, 2, -1);
        exp_disp = bump(exp_disp, 2, -1);
        push("dec_wrap", 32'(exp_disp));
        press_dec(2);
        press_dec(2);
        chk(display_digits);

        push("inc_dec_same", 32'(exp_disp));
        inc_btn[2] = 1'b1;
        dec_btn[2] = 1'b1;
        tick();
        inc_btn[2] = 1'b0;
        dec_btn[2] = 1'b0;
        tick();
        chk(display_digits);
`else
        push("dec_ignored", 32'(exp_disp));
        press_dec(2);
        press_dec(0);
        chk(display_digits);
`endif

        // Lock while a guess is pending discards it without counting.
        push("lk_pending", 32'h1);
        press_confirm();
        chk(state);

        push("lk_valid", 32'h0);
        push("lk_state", 32'h2);
        push("lk_count", 32'h1);
        lock = 1'b1;
        tick();
        chk(guess_valid);
        chk(state);
        chk(guess_count);

        push("lk_frozen", 32'(exp_disp));
        press_inc(0);
        press_confirm();
        chk(display_digits);

        push("unlk_state", 32'h0);
        push("unlk_display", 32'(exp_disp));
        push("unlk_valid", 32'h0);
        lock = 1'b0;
        tick();
        chk(state);
        chk(display_digits);
        chk(guess_valid);

        // Button held across restart must not count until re-pressed.
        inc_btn[0] = 1'b1;
        restart    = 1'b1;
        tick(2);
        restart = 1'b0;
        tick(3);
        exp_disp = '0;
        push("held_through_rst", 32'(exp_disp));
        chk(display_digits);

        inc_btn[0] = 1'b0;
        tick();
        exp_disp = bump(exp_disp, 0, 1);
        push("repress", 32'(exp_disp));
        press_inc(0);
        chk(display_digits);

        for (int k = 0; k < 5; k++) begin
            int t;
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
            t = 0;
            while (!guess_valid && t < 10) begin
                tick();
                t++;
            end
            push("valid_wait", 32'h1);
            chk(guess_valid);
            guess_ack = 1'b1;
            tick();
            guess_ack = 1'b0;
            tick();
        end
        push("count_saturate", 32'h3);
        chk(guess_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_guess_entry
`default_nettype wire
